cache_assoc: RTL
================

Name: cache_assoc

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache.
- Successor to the direct-mapped cache; generalised in sets, ways and line width.
- Adds true-LRU replacement and an explicit miss FSM that serialises writeback then refill.
- Sits between the pipeline (data or instruction port) and the line-wide memory interface.

Parameters:
- ARCH_BITS, 32, address/data word width.
- BYTE_BITS, 8, byte width.
- LINE_BITS_W, 128, cache and memory line width; multiple of ARCH_BITS.
- SETS, 4, number of sets; power of two, ≥1.
- WAYS, 2, associativity; power of two, 1..8.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- RE  in  1  read request, held until rValid
- rByte  in  1  1 = byte read (sign-extended), 0 = word
- rAddr  in  ARCH_BITS  read address
- rData  out  ARCH_BITS  read data
- rValid  out  1  read hit this cycle
- WE  in  1  write request, held until wAck
- wByte  in  1  1 = byte write, 0 = word
- wAddr  in  ARCH_BITS  write address
- wData  in  ARCH_BITS  write data (low byte used when wByte)
- wAck  out  1  write performed at this edge
- readMemAddr  out  ARCH_BITS  line-aligned refill address
- readMemReq  out  1  refill request
- readMemData  in  LINE_BITS_W  refill line
- readMemLineValid  in  1  refill data valid
- writeMemAddr  out  ARCH_BITS  line-aligned writeback address
- writeMemLine  out  LINE_BITS_W  evicted line
- writeMemReq  out  1  writeback request
- writeMemAck  in  1  writeback accepted

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset:
  - All valid/dirty bits cleared; LRU ages set to way index; FSM to IDLE.
  - All outputs 0 (rData 0).
  - Reset mid-miss drops the transaction; memory-side requests deassert the next cycle.
- Address split: tag | set (log2 SETS) | word offset | byte offset (log2(ARCH_BITS/BYTE_BITS)). Unaligned word accesses are illegal.
- Line layout: word w at bits [w*ARCH_BITS +: ARCH_BITS]; byte b of a word at [b*BYTE_BITS +: BYTE_BITS].
- Read hit: combinational, same cycle.
  - rValid = RE & hit & FSM in IDLE.
  - rData is the word, or the sign-extended byte when rByte.
  - rData is don't-care when rValid = 0.
- Write hit: wAck combinational in the same cycle as WE.
  - Word or byte merged into the way at the posedge; dirty set.
  - The merge is visible to a read of the same address in the following cycle.
- LRU: per-set ages of log2(WAYS) bits. On every hit or fill, the touched way becomes age 0 and ways younger than it increment.
- Victim selection: lowest-index invalid way; otherwise the way with age WAYS-1.
- FSM states: IDLE, WB, FILL.
  - IDLE → WB on a miss where the victim is valid and dirty.
  - IDLE → FILL on a miss with a clean or invalid victim.
  - WB: writeMemReq = 1; writeMemAddr/writeMemLine are the victim's. On writeMemAck, clear the victim's valid and dirty bits and go to FILL.
  - FILL: readMemReq = 1; readMemAddr is the miss address with the offset zeroed. On readMemLineValid, install line and tag, set valid, clear dirty, update LRU, return to IDLE.
  - The hit is then reported from IDLE in the next cycle.
- Miss latency: 1 cycle after memory response.
- Simultaneous read and write:
  - Both hit: both served in the same cycle.
  - Both miss: the read miss is serviced first, then the write.
  - One hits: the hit is served in IDLE while the other starts the FSM.
- No hits are reported outside IDLE. Miss target address and victim are latched on FSM entry; the requester must hold its inputs stable.
- Refill of the same set as a pending write: the write re-evaluates after IDLE.
- WAYS = 1 degenerates to direct-mapped; LRU logic is absent.

Optional Feature:
- Macro: CACHE_ASSOC_PERF_EN.
- When defined, adds outputs perfHits[31:0], perfMisses[31:0], perfWritebacks[31:0].
  - perfHits counts each cycle with rValid or wAck.
  - perfMisses counts each IDLE→WB/FILL transition.
  - perfWritebacks counts each writeMemAck accepted in WB.
  - All counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined, none of these ports or counters exist; all other behaviour is identical.

Test Plan:
- After reset, RE=1, rAddr=0x100 → readMemReq=1, readMemAddr=0x100; supply line with word0=0xDEADBEEF and readMemLineValid → next cycle rValid=1, rData=0xDEADBEEF.
- Byte read: rByte=1 of byte 0x80 at 0x101 (hit) → rData=0xFFFFFF80, same cycle as RE.
- WAYS=2, SETS=4: fill 0x000 and 0x040 (same set), write 0x11223344 to 0x000, then read 0x080 → writeMemReq=1, writeMemAddr=0x040? No: LRU victim is 0x040 (clean), so no writeback; readMemReq for 0x080. Then read 0x0C0 → victim 0x000 (dirty), so writeMemReq=1, writeMemAddr=0x000 with word0=0x11223344 before the refill.
- Simultaneous RE miss at 0x200 and WE miss at 0x300 → refill 0x200 first, rValid; then refill 0x300, wAck.
- rst asserted during FILL with readMemReq=1 → next cycle readMemReq=0; a later read of the same address misses.
- With CACHE_ASSOC_PERF_EN: 3 hits, 2 misses, 1 writeback → perfHits=3, perfMisses=2, perfWritebacks=1.

Source files
------------

// File: rtl/cache_assoc.sv
// rtl/cache_assoc.sv - N-way set-associative write-back write-allocate cache
//
// Purpose: pipeline-side cache with true-LRU replacement and a miss FSM
// (IDLE -> WB -> FILL) that writes back a dirty victim before refilling.
// Optional build macro: CACHE_ASSOC_PERF_EN adds saturating perf counters.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   RE, rByte, rAddr         read request (held until rValid), byte/word, address
//   rData, rValid            read data (sign-extended byte when rByte), hit strobe
//   WE, wByte, wAddr, wData  write request (held until wAck), byte/word, address, data
//   wAck                     write performed at this edge
//   readMemAddr/Req          line-aligned refill request
//   readMemData/LineValid    refill line and its valid strobe
//   writeMemAddr/Line/Req    writeback of the evicted line
//   writeMemAck              writeback accepted
//   perfHits/Misses/Writebacks (CACHE_ASSOC_PERF_EN only) event counters

module cache_assoc #(
   parameter int ARCH_BITS   = 32,
   parameter int BYTE_BITS   = 8,
   parameter int LINE_BITS_W = 128,
   parameter int SETS        = 4,
   parameter int WAYS        = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   RE,
   input  logic                   rByte,
   input  logic [ARCH_BITS-1:0]   rAddr,
   output logic [ARCH_BITS-1:0]   rData,
   output logic                   rValid,
   input  logic                   WE,
   input  logic                   wByte,
   input  logic [ARCH_BITS-1:0]   wAddr,
   input  logic [ARCH_BITS-1:0]   wData,
   output logic                   wAck,
   output logic [ARCH_BITS-1:0]   readMemAddr,
   output logic                   readMemReq,
   input  logic [LINE_BITS_W-1:0] readMemData,
   input  logic                   readMemLineValid,
   output logic [ARCH_BITS-1:0]   writeMemAddr,
   output logic [LINE_BITS_W-1:0] writeMemLine,
   output logic                   writeMemReq,
   input  logic                   writeMemAck
`ifdef CACHE_ASSOC_PERF_EN
   ,
   output logic [31:0]            perfHits,
   output logic [31:0]            perfMisses,
   output logic [31:0]            perfWritebacks
`endif
);

   localparam int WORDS   = LINE_BITS_W / ARCH_BITS;
   localparam int BPW     = ARCH_BITS / BYTE_BITS;
   localparam int BOFF_W  = $clog2(BPW);
   localparam int WOFF_W  = $clog2(WORDS);
   localparam int OFF_W   = BOFF_W + WOFF_W;
   localparam int SET_LOG = $clog2(SETS);
   localparam int TAG_W   = ARCH_BITS - OFF_W - SET_LOG;
   localparam int SET_W   = (SETS > 1)  ? SET_LOG         : 1;
   localparam int WORD_W  = (WORDS > 1) ? WOFF_W          : 1;
   localparam int BYTE_W  = (BPW > 1)   ? BOFF_W          : 1;
   localparam int WAY_W   = (WAYS > 1)  ? $clog2(WAYS)    : 1;
   localparam logic [ARCH_BITS-1:0] OFF_MASK = ARCH_BITS'((64'd1 << OFF_W) - 64'd1);

   typedef logic [WAYS-1:0][WAY_W-1:0] ageVec_t;
   typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

   logic [LINE_BITS_W-1:0] lineData [SETS][WAYS];
   logic [TAG_W-1:0]       tagArr   [SETS][WAYS];
   logic [WAYS-1:0]        validArr [SETS];
   logic [WAYS-1:0]        dirtyArr [SETS];
   ageVec_t                ageArr   [SETS];

   state_t                 state, nextState;
   logic [ARCH_BITS-1:0]   missAddr;
   logic [WAY_W-1:0]       missWay;
   logic [SET_W-1:0]       missSet;

   logic [SET_W-1:0]       rSet, wSet, reqSet;
   logic [TAG_W-1:0]       rTag, wTag;
   logic                   rHit, wHit;
   logic [WAY_W-1:0]       rWay, wWay, vicWay;
   logic                   vicDirty, missStart, readMiss, writeMiss;
   logic [ARCH_BITS-1:0]   reqAddr, rWord;
   ageVec_t                ageR, ageW;

   function automatic logic [SET_W-1:0] setOf(input logic [ARCH_BITS-1:0] a);
      if (SETS > 1) return a[OFF_W +: SET_W];
      return '0;
   endfunction

   function automatic logic [TAG_W-1:0] tagOf(input logic [ARCH_BITS-1:0] a);
      return a[ARCH_BITS-1 -: TAG_W];
   endfunction

   function automatic logic [WORD_W-1:0] wordOf(input logic [ARCH_BITS-1:0] a);
      if (WORDS > 1) return a[BOFF_W +: WORD_W];
      return '0;
   endfunction

   function automatic logic [BYTE_W-1:0] byteOf(input logic [ARCH_BITS-1:0] a);
      if (BPW > 1) return a[0 +: BYTE_W];
      return '0;
   endfunction

   function automatic logic [ARCH_BITS-1:0] lineAddr(input logic [TAG_W-1:0] t,
                                                     input logic [SET_W-1:0] s);
      logic [ARCH_BITS-1:0] a;
      a = '0;
      a[ARCH_BITS-1 -: TAG_W] = t;
      if (SETS > 1) a[OFF_W +: SET_W] = s;
      return a;
   endfunction

   function automatic logic [ARCH_BITS-1:0] getWord(input logic [LINE_BITS_W-1:0] l,
                                                    input logic [WORD_W-1:0] idx);
      logic [ARCH_BITS-1:0] r;
      r = '0;
      for (int i = 0; i < WORDS; i++)
         if (WORD_W'(i) == idx) r = l[i*ARCH_BITS +: ARCH_BITS];
      return r;
   endfunction

   function automatic logic [BYTE_BITS-1:0] getByte(input logic [ARCH_BITS-1:0] w,
                                                    input logic [BYTE_W-1:0] idx);
      logic [BYTE_BITS-1:0] r;
      r = '0;
      for (int i = 0; i < BPW; i++)
         if (BYTE_W'(i) == idx) r = w[i*BYTE_BITS +: BYTE_BITS];
      return r;
   endfunction

   function automatic logic [LINE_BITS_W-1:0] mergeLine(input logic [LINE_BITS_W-1:0] l,
                                                        input logic [WORD_W-1:0] wi,
                                                        input logic [BYTE_W-1:0] bi,
                                                        input logic isByte,
                                                        input logic [ARCH_BITS-1:0] d);
      logic [LINE_BITS_W-1:0] r;
      r = l;
      for (int i = 0; i < WORDS; i++) begin
         if (WORD_W'(i) == wi) begin
            if (isByte) begin
               for (int b = 0; b < BPW; b++)
                  if (BYTE_W'(b) == bi) r[i*ARCH_BITS + b*BYTE_BITS +: BYTE_BITS] = d[BYTE_BITS-1:0];
            end else begin
               r[i*ARCH_BITS +: ARCH_BITS] = d;
            end
         end
      end
      return r;
   endfunction

   // Touched way becomes youngest; only ways younger than it age by one,
   // so ages stay a permutation of 0..WAYS-1.
   function automatic ageVec_t touch(input ageVec_t a, input logic [WAY_W-1:0] way);
      ageVec_t r;
      r = a;
      if (WAYS > 1) begin
         for (int i = 0; i < WAYS; i++) begin
            if (WAY_W'(i) == way)   r[i] = '0;
            else if (a[i] < a[way]) r[i] = a[i] + 1'b1;
         end
      end
      return r;
   endfunction

   assign rSet    = setOf(rAddr);
   assign rTag    = tagOf(rAddr);
   assign wSet    = setOf(wAddr);
   assign wTag    = tagOf(wAddr);
   assign missSet = setOf(missAddr);

   always_comb begin
      rHit = 1'b0;
      rWay = '0;
      wHit = 1'b0;
      wWay = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (!rHit && validArr[rSet][i] && tagArr[rSet][i] == rTag) begin
            rHit = 1'b1;
            rWay = WAY_W'(i);
         end
         if (!wHit && validArr[wSet][i] && tagArr[wSet][i] == wTag) begin
            wHit = 1'b1;
            wWay = WAY_W'(i);
         end
      end
   end

   // Read miss takes priority when both ports miss together.
   always_comb begin
      readMiss  = RE && !rHit;
      writeMiss = WE && !wHit;
      missStart = (state == IDLE) && (readMiss || writeMiss);
      reqAddr   = readMiss ? rAddr : wAddr;
      reqSet    = setOf(reqAddr);
   end

   always_comb begin
      logic found;
      found  = 1'b0;
      vicWay = '0;
      for (int i = WAYS-1; i >= 0; i--) begin
         if (!validArr[reqSet][i]) begin
            vicWay = WAY_W'(i);
            found  = 1'b1;
         end
      end
      if (!found)
         for (int i = 0; i < WAYS; i++)
            if (ageArr[reqSet][i] == WAY_W'(WAYS-1)) vicWay = WAY_W'(i);
      // A write hit landing on the victim this very cycle makes it dirty.
      vicDirty = validArr[reqSet][vicWay] &&
                 (dirtyArr[reqSet][vicWay] || (wAck && wSet == reqSet && wWay == vicWay));
   end

   always_comb begin
      ageR = touch(ageArr[rSet], rWay);
      ageW = touch((rValid && rSet == wSet) ? ageR : ageArr[wSet], wWay);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (missStart) nextState = vicDirty ? WB : FILL;
         WB:      if (writeMemAck) nextState = FILL;
         FILL:    if (readMemLineValid) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      rValid       = RE && rHit && (state == IDLE);
      wAck         = WE && wHit && (state == IDLE);
      rWord        = getWord(lineData[rSet][rWay], wordOf(rAddr));
      rData        = '0;
      if (rValid)
         rData = rByte ? ARCH_BITS'($signed(getByte(rWord, byteOf(rAddr)))) : rWord;
      readMemReq   = (state == FILL);
      readMemAddr  = readMemReq ? (missAddr & ~OFF_MASK) : '0;
      writeMemReq  = (state == WB);
      writeMemAddr = writeMemReq ? lineAddr(tagArr[missSet][missWay], missSet) : '0;
      writeMemLine = writeMemReq ? lineData[missSet][missWay] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            validArr[s] <= '0;
            dirtyArr[s] <= '0;
            for (int w = 0; w < WAYS; w++) ageArr[s][w] <= WAY_W'(w);
         end
         missAddr <= '0;
         missWay  <= '0;
      end else begin
         if (missStart) begin
            missAddr <= reqAddr;
            missWay  <= vicWay;
         end
         if (rValid) ageArr[rSet] <= ageR;
         if (wAck) begin
            lineData[wSet][wWay] <= mergeLine(lineData[wSet][wWay], wordOf(wAddr),
                                              byteOf(wAddr), wByte, wData);
            dirtyArr[wSet][wWay] <= 1'b1;
            ageArr[wSet]         <= ageW;
         end
         if (state == WB && writeMemAck) begin
            validArr[missSet][missWay] <= 1'b0;
            dirtyArr[missSet][missWay] <= 1'b0;
         end
         if (state == FILL && readMemLineValid) begin
            lineData[missSet][missWay] <= readMemData;
            tagArr[missSet][missWay]   <= tagOf(missAddr);
            validArr[missSet][missWay] <= 1'b1;
            dirtyArr[missSet][missWay] <= 1'b0;
            ageArr[missSet]            <= touch(ageArr[missSet], missWay);
         end
      end
   end

`ifdef CACHE_ASSOC_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perfHits       <= '0;
         perfMisses     <= '0;
         perfWritebacks <= '0;
      end else begin
         if ((rValid || wAck) && perfHits != 32'hFFFF_FFFF)
            perfHits <= perfHits + 32'd1;
         if (missStart && perfMisses != 32'hFFFF_FFFF)
            perfMisses <= perfMisses + 32'd1;
         if (state == WB && writeMemAck && perfWritebacks != 32'hFFFF_FFFF)
            perfWritebacks <= perfWritebacks + 32'd1;
      end
   end
`endif

endmodule
